alu_iterative_exec: RTL and testbench

- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU control decoder, together with two operands.
- Single-cycle for logic, arithmetic and compare ops; iterative barrel-free shifter for SLL/SRL/SRA, at SHIFT_STEP bits per cycle.
- Valid/ready handshake on input and output, so the multicycle datapath can stall on it.

---
 rtl/alu_iterative_exec_if.sv | 25 ++
 rtl/alu_iterative_exec.sv | 147 ++++++++++++++
 tb/tb_alu_iterative_exec.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_iterative_exec_if.sv
// Operand/result handshake bundle for the iterative execute-stage ALU.
// The issuing stage uses the master modport and the ALU uses the slave modport.
interface alu_iterative_exec_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative shifter moving
// SHIFT_STEP bits per cycle, valid/ready handshake on both sides.
module alu_iterative_exec #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_iterative_exec_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
    // One extra bit so SHIFT_STEP == DATA_WIDTH is representable.
    localparam int unsigned CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    typedef enum logic [3:0] {
        OpAnd  = 4'b0000,
        OpOr   = 4'b0001,
        OpAdd  = 4'b0010,
        OpXor  = 4'b0011,
        OpSll  = 4'b0100,
        OpSrl  = 4'b0101,
        OpSub  = 4'b0110,
        OpSra  = 4'b0111,
        OpSlt  = 4'b1000,
        OpSltu = 4'b1001,
        OpEq   = 4'b1010
    } op_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;

    logic                  accept;
    logic                  is_shift;
    logic [CNT_W-1:0]      shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [CNT_W-1:0]      step;
    logic [DATA_WIDTH-1:0] shifted;

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign shamt    = {1'b0, bus.SrcB[SHAMT_W-1:0]};
    assign is_shift = (bus.Operation == OpSll) || (bus.Operation == OpSrl) ||
                      (bus.Operation == OpSra);

    // Single-cycle datapath; illegal codes fall through to zero.
    always_comb begin
        alu_res = '0;
        case (bus.Operation)
            OpAnd:   alu_res = bus.SrcA & bus.SrcB;
            OpOr:    alu_res = bus.SrcA | bus.SrcB;
            OpAdd:   alu_res = bus.SrcA + bus.SrcB;
            OpXor:   alu_res = bus.SrcA ^ bus.SrcB;
            OpSub:   alu_res = bus.SrcA - bus.SrcB;
            OpSlt:   alu_res = DATA_WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
            OpSltu:  alu_res = DATA_WIDTH'(bus.SrcA < bus.SrcB);
            OpEq:    alu_res = DATA_WIDTH'(bus.SrcA == bus.SrcB);
            default: alu_res = '0;
        endcase
    end

    // One shifter iteration on the accumulator, never overshooting the remaining count.
    always_comb begin
        step    = (cnt_q < STEP) ? cnt_q : STEP;
        shifted = acc_q;
        case (op_q)
            OpSll:   shifted = acc_q << step;
            OpSrl:   shifted = acc_q >> step;
            OpSra:   shifted = $unsigned($signed(acc_q) >>> step);
            default: shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_shift) begin
                        acc_d = bus.SrcA;
                        cnt_d = shamt;
                        op_d  = bus.Operation;
                        if (shamt == '0) begin
                            result_d = bus.SrcA;
                            zero_d   = (bus.SrcA == '0);
                            state_d  = StDone;
                        end else begin
                            state_d = StShift;
                        end
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = StDone;
                    end
                end
            end
            StShift: begin
                acc_d = shifted;
                cnt_d = cnt_q - step;
                if (cnt_q == step) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec: one instance with SHIFT_STEP=1 and one
// with SHIFT_STEP=8, driven and sampled 1ns after each rising edge.
module tb_alu_iterative_exec;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    alu_iterative_exec_if #(.DATA_WIDTH(32)) if1 ();
    alu_iterative_exec_if #(.DATA_WIDTH(32)) if8 ();

    alu_iterative_exec #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    alu_iterative_exec #(.DATA_WIDTH(32), .SHIFT_STEP(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            if8.in_valid = v; if8.Operation = op; if8.SrcA = a; if8.SrcB = b;
        end else begin
            if1.in_valid = v; if1.Operation = op; if1.SrcA = a; if1.SrcB = b;
        end
    endtask

    task automatic set_ready(input bit sel, input logic r);
        if (sel) if8.out_ready = r;
        else     if1.out_ready = r;
    endtask

    function automatic logic get_ov(input bit sel);
        return sel ? if8.out_valid : if1.out_valid;
    endfunction

    function automatic logic get_ir(input bit sel);
        return sel ? if8.in_ready : if1.in_ready;
    endfunction

    function automatic logic [31:0] get_res(input bit sel);
        return sel ? if8.ALUResult : if1.ALUResult;
    endfunction

    function automatic logic get_z(input bit sel);
        return sel ? if8.Zero : if1.Zero;
    endfunction

    // Issue one op (called 1ns after an edge), check latency, result, Zero and return to idle.
    task automatic run_op(input string tag, input bit sel, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        set_ready(sel, 1'b1);
        check({tag, ".in_ready"}, 32'(get_ir(sel)), 32'd1);
        drive(sel, 1'b1, op, a, b);
        @(posedge clk); #1;
        // Scramble inputs so only captured values can produce the result.
        drive(sel, 1'b0, 4'b0010, $urandom, $urandom);
        lat = 1;
        while (!get_ov(sel) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, get_res(sel), exp_res);
        check({tag, ".zero"}, 32'(get_z(sel)), 32'(exp_res == 32'd0));
        @(posedge clk); #1;
        check({tag, ".out_valid_drop"}, 32'(get_ov(sel)), 32'd0);
        check({tag, ".in_ready_back"}, 32'(get_ir(sel)), 32'd1);
        check({tag, ".result_held"}, get_res(sel), exp_res);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        set_ready(1'b0, 1'b1);
        set_ready(1'b1, 1'b1);
        #12;
        check("rst.out_valid", 32'(if1.out_valid), 32'd0);
        check("rst.result", if1.ALUResult, 32'd0);
        check("rst.zero", 32'(if1.Zero), 32'd1);
        check("rst.in_ready", 32'(if1.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1);
        run_op("sub_zero", 1'b0, 4'b0110, 32'd3, 32'd3, 32'd0, 1);
        run_op("add_wrap", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("and", 1'b0, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
        run_op("or", 1'b0, 4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
        run_op("sra4", 1'b0, 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
        run_op("srl4", 1'b0, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 5);
        // Amount field is SrcB[4:0]; 32 decodes to a zero shift.
        run_op("sll0", 1'b0, 4'b0100, 32'h0000_1234, 32'd32, 32'h0000_1234, 1);
        run_op("sll31", 1'b0, 4'b0100, 32'd1, 32'd31, 32'h8000_0000, 32);
        run_op("s8.sra31", 1'b1, 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 5);
        run_op("s8.sll8", 1'b1, 4'b0100, 32'd1, 32'd8, 32'h0000_0100, 2);
        run_op("s8.srl3", 1'b1, 4'b0101, 32'h0000_00F0, 32'd3, 32'h0000_001E, 2);
        run_op("slt", 1'b0, 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("sltu", 1'b0, 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("eq", 1'b0, 4'b1010, 32'h0000_1234, 32'h0000_1234, 32'd1, 1);
        run_op("illegal", 1'b0, 4'b1111, 32'd5, 32'd9, 32'd0, 1);

        // Backpressure: XOR result stalls 3 cycles while a new ADD waits on in_valid.
        set_ready(1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'b0011, 32'h0000_00FF, 32'h0000_000F);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'b0010, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("bp.out_valid", 32'(if1.out_valid), 32'd1);
            check("bp.result", if1.ALUResult, 32'h0000_00F0);
            check("bp.zero", 32'(if1.Zero), 32'd0);
            check("bp.in_ready", 32'(if1.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bp.still_valid", 32'(if1.out_valid), 32'd1);
        set_ready(1'b0, 1'b1);
        @(posedge clk); #1;
        check("bp.hs_out_valid", 32'(if1.out_valid), 32'd0);
        check("bp.hs_in_ready", 32'(if1.in_ready), 32'd1);
        check("bp.hs_result_held", if1.ALUResult, 32'h0000_00F0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        check("bp.next_valid", 32'(if1.out_valid), 32'd1);
        check("bp.next_result", if1.ALUResult, 32'd3);
        @(posedge clk); #1;
        check("bp.next_idle", 32'(if1.in_ready), 32'd1);

        // Asynchronous reset in the middle of an SLL by 20.
        drive(1'b0, 1'b1, 4'b0100, 32'd1, 32'd20);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(if1.out_valid), 32'd0);
        check("arst.result", if1.ALUResult, 32'd0);
        check("arst.zero", 32'(if1.Zero), 32'd1);
        check("arst.in_ready", 32'(if1.in_ready), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            if (if1.out_valid) break;
            @(posedge clk); #1;
        end
        check("arst.no_stale", 32'(if1.out_valid), 32'd0);
        run_op("arst.add", 1'b0, 4'b0010, 32'd100, 32'd23, 32'd123, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
